blink_timer: RTL
================

Name: blink_timer

Overview:
- Downstream consumer of the speed shifter's 8-bit timer load value.
- Divides the system clock by a fixed prescaler to get a base tick.
- Counts down from the load value in base ticks; at each expiry it toggles the LED drive and emits a one-cycle pulse.
- Sits between the speed shifter and the LED output of the blinker datapath.

Parameters:
- PRESCALE, 1000: clk cycles per base tick. Must be ≥2.
- PRE_W, 10: prescaler counter width. Must satisfy 2^PRE_W ≥ PRESCALE.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- load_val  input  8  timer load value from the speed shifter (e.g. (speed<<dist)-1).
- enable  input  1  run/hold control for prescaler and countdown.
- count  output  8  current countdown value, registered.
- expire  output  1  one-cycle pulse on each countdown expiry, registered.
- blink  output  1  LED drive; toggles on each expiry, registered.

Behaviour:
- Reset (async, any time, including mid-count): pre_cnt=0, count=0, blink=0, expire=0. All outputs are low/zero while rst=1.
- Prescaler:
  - pre_cnt increments only when enable=1; it wraps from PRESCALE-1 to 0.
  - tick is internal and combinational: tick = enable && (pre_cnt == PRESCALE-1).
- Countdown, on a rising edge with tick=1:
  - count==0: count<=load_val, blink<=~blink, expire<=1.
  - count!=0: count<=count-1, expire<=0.
- On any edge without tick: count and blink hold, expire<=0. expire is therefore never high for 2 consecutive cycles.
- enable=0 freezes pre_cnt, count and blink. Re-asserting enable resumes from the frozen state with no lost or extra cycles.
- First expiry after reset occurs on the first tick, because count starts at 0.
- Steady-state blink half-period is (load_val+1)*PRESCALE clk cycles.
- load_val=0: expiry on every tick, so blink toggles every PRESCALE cycles.
- load_val=255: half-period is 256*PRESCALE cycles. Arithmetic is unsigned 8-bit, with no wrap below 0 because the decrement is never applied at 0.
- load_val change mid-count: the new value is sampled only at the next reload. The current countdown completes with the old value.
- Latency: count, blink and expire all update on the same edge as the tick.

Optional Feature:
- Macro BLINK_TIMER_RELOAD_ON_CHANGE_EN.
- Defined:
  - Adds an internal 8-bit register last_val, reset to 0, which captures load_val on every edge.
  - When load_val != last_val and enable=1: count<=load_val and pre_cnt<=0 on that edge, with blink unchanged and expire=0.
  - This takes priority over tick on the same edge, so a speed change is visible immediately.
- Not defined: load_val is sampled only at expiry, as above, and last_val does not exist.

Test Plan (PRESCALE=4, PRE_W=3):
- Reset with load_val=2, enable=1 from release → expire high for one cycle after enabled edges 4, 16, 28. blink reads 1, 0, 1 after those edges. count sequence is 2, 1, 0, 2, ..., stepping every 4 edges.
- load_val=0, enable=1 → expire on every 4th edge; blink is a square wave with period 8 clk cycles.
- enable dropped for 10 cycles after edge 6 with load_val=2 → count, blink and pre_cnt are held. Next expiry lands at edge 26 instead of 16.
- rst asserted asynchronously mid-count (count=1, blink=1) → outputs go to 0/0/0 before the next clk edge. Behaviour after release matches the first scenario.
- load_val changes from 2 to 5 while count=2, macro off → current count finishes (2, 1, 0), then reloads 5. Next half-period is 24 cycles.
- Same stimulus with BLINK_TIMER_RELOAD_ON_CHANGE_EN defined → count=5 and pre_cnt=0 on the edge after the change. blink does not change, and there is no expire pulse on that edge.

Source files
------------

// File: rtl/blink_timer.sv
// Prescaled countdown timer driving the blinker LED: reloads from load_val on expiry, toggles blink, pulses expire.
// Optional build macro BLINK_TIMER_RELOAD_ON_CHANGE_EN restarts the countdown as soon as load_val changes.
module blink_timer #(
    parameter int PRESCALE = 1000,
    parameter int PRE_W    = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] load_val,
    input  logic       enable,
    output logic [7:0] count,
    output logic       expire,
    output logic       blink
);

    if (PRESCALE < 2) begin : g_bad_prescale
        $error("blink_timer: PRESCALE must be at least 2");
    end
    if ((64'd1 << PRE_W) < 64'(PRESCALE)) begin : g_bad_pre_w
        $error("blink_timer: PRE_W too narrow for PRESCALE");
    end

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    logic [PRE_W-1:0] pre_cnt;
    logic             tick;

    assign tick = enable && (pre_cnt == PRE_LAST);

`ifdef BLINK_TIMER_RELOAD_ON_CHANGE_EN
    logic [7:0] last_val;
    logic       val_changed;

    assign val_changed = enable && (load_val != last_val);

    // last_val tracks load_val on every edge, independent of enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_val <= 8'd0;
        end else begin
            last_val <= load_val;
        end
    end
`else
    logic val_changed;

    assign val_changed = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt <= '0;
            count   <= 8'd0;
            blink   <= 1'b0;
            expire  <= 1'b0;
        end else if (val_changed) begin
            // A speed change restarts the countdown at once; blink keeps its phase.
            pre_cnt <= '0;
            count   <= load_val;
            expire  <= 1'b0;
        end else if (tick) begin
            pre_cnt <= '0;
            if (count == 8'd0) begin
                count  <= load_val;
                blink  <= ~blink;
                expire <= 1'b1;
            end else begin
                count  <= count - 8'd1;
                expire <= 1'b0;
            end
        end else begin
            if (enable) begin
                pre_cnt <= pre_cnt + PRE_W'(1);
            end
            expire <= 1'b0;
        end
    end

endmodule
